// File: rtl/uart_tx_periph_pkg.sv
// rtl/uart_tx_periph_pkg.sv - register map, STATUS bit layout and transmitter states
package uart_tx_periph_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A programmed divisor of zero behaves as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the transmitter; push is refused when full even if popping
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == 5'(DEPTH));
  assign empty   = (cnt == 5'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped UART transmitter: register decode, TX FIFO and 8N1 serializer
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic        mem_wr_sig_i,
  output logic [31:0] mem_rd_data_o,
  output logic        tx_o
);

  logic       hit;
  logic [1:0] offset;
  logic       wr_data_reg;
  logic       wr_status;
  logic       wr_div;
  logic       unused_bits;

  assign hit         = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset      = mem_addr_i[3:2];
  assign wr_data_reg = mem_wr_sig_i && hit && (offset == REG_DATA);
  assign wr_status   = mem_wr_sig_i && hit && (offset == REG_STATUS);
  assign wr_div      = mem_wr_sig_i && hit && (offset == REG_DIV);
  assign unused_bits = ^{mem_addr_i[1:0], mem_wr_data_i[31:16]};

  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_data_reg),
    .push_data (mem_wr_data_i[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  logic [15:0] div_q;
  logic        ovf_q;

  // A dropped push in the same cycle as a clear request leaves overflow set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      if (wr_div) div_q <= mem_wr_data_i[15:0];
      if (wr_data_reg && fifo_full)                ovf_q <= 1'b1;
      else if (wr_status && mem_wr_data_i[ST_OVF]) ovf_q <= 1'b0;
    end
  end

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] bdiv_q, bdiv_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (baud_q == bdiv_q - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      bdiv_q  <= eff_div(DIV_RESET);
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      bdiv_q  <= bdiv_d;
      tx_q    <= tx_d;
    end
  end

  // The line is registered, so it trails the state by one cycle; every level still lasts bdiv cycles.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    bdiv_d   = bdiv_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    if (state_q != TX_IDLE) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          bdiv_d   = eff_div(div_q);
          baud_d   = 16'd0;
          bit_d    = 3'd0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_o = tx_q;

  always_comb begin
    mem_rd_data_o = '0;
    if (hit) begin
      case (offset)
        REG_STATUS: begin
          mem_rd_data_o[ST_BUSY]            = (state_q != TX_IDLE);
          mem_rd_data_o[ST_FULL]            = fifo_full;
          mem_rd_data_o[ST_EMPTY]           = fifo_empty;
          mem_rd_data_o[ST_OVF]             = ovf_q;
          mem_rd_data_o[ST_CNT_LSB +: 5]    = fifo_count;
        end
        REG_DIV: mem_rd_data_o[15:0] = div_q;
        default: mem_rd_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - randomized bench for uart_tx_periph against a frame-level line model
module tb_uart_tx_periph;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_DATA   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DIV    = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wr_data_i = '0;
  logic        mem_wr_sig_i = 1'b0;
  logic [31:0] mem_rd_data_o;
  logic        tx_o;

  int n_vec = 0;
  int n_miss = 0;

  uart_tx_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd868)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_i    (mem_addr_i),
    .mem_wr_data_i (mem_wr_data_i),
    .mem_wr_sig_i  (mem_wr_sig_i),
    .mem_rd_data_o (mem_rd_data_o),
    .tx_o          (tx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending bytes plus the record of the frame last started.
  logic [7:0]  mq[$];
  logic [15:0] m_div = 16'd868;
  logic        m_ovf = 1'b0;
  int          cyc = 0;
  int          idle_from = 0;
  int          fr_p = 0;
  int          fr_d = 1;
  logic [7:0]  fr_byte = '0;
  logic        fr_valid = 1'b0;
  int          was_size;
  logic        ovf_set;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_div = 16'd868; m_ovf = 1'b0; cyc = 0; idle_from = 0;
      fr_p = 0; fr_d = 1; fr_byte = '0; fr_valid = 1'b0;
    end else begin
      cyc++;
      was_size = mq.size();
      if (cyc >= idle_from && was_size > 0) begin
        fr_byte   = mq.pop_front();
        fr_p      = cyc;
        fr_d      = (m_div == 16'd0) ? 1 : int'(m_div);
        fr_valid  = 1'b1;
        idle_from = cyc + 10 * fr_d + 1;
      end
      ovf_set = 1'b0;
      if (mem_wr_sig_i && mem_addr_i[31:4] == BASE[31:4]) begin
        case (mem_addr_i[3:2])
          2'd0: if (was_size < DEPTH) mq.push_back(mem_wr_data_i[7:0]); else ovf_set = 1'b1;
          2'd1: if (mem_wr_data_i[3]) m_ovf = 1'b0;
          2'd2: m_div = mem_wr_data_i[15:0];
          default: ;
        endcase
      end
      if (ovf_set) m_ovf = 1'b1;
    end
  end

  function automatic logic exp_tx();
    int k, idx;
    if (!fr_valid || cyc - 1 < fr_p) return 1'b1;
    k = cyc - 1 - fr_p;
    if (k >= 10 * fr_d) return 1'b1;
    idx = k / fr_d;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fr_byte[idx-1];
  endfunction

  function automatic logic [31:0] exp_status();
    int   sz = mq.size();
    logic busy = fr_valid && (cyc < fr_p + 10 * fr_d);
    return {23'b0, 5'(sz), m_ovf, (sz == 0), (sz == DEPTH), busy};
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return '0;
    case (a[1+2:2])
      2'd1:    return exp_status();
      2'd2:    return {16'b0, m_div};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    if (reset_n) chk("tx_line", tx_o, exp_tx());
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr_i = a; mem_wr_data_i = d; mem_wr_sig_i = 1'b1;
  endtask

  task automatic bus_nowr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr_i = a; mem_wr_data_i = d; mem_wr_sig_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_addr_i = a; mem_wr_sig_i = 1'b0;
    #1 d = mem_rd_data_o;
  endtask

  task automatic bus_rd_chk(input string tag, input logic [31:0] a);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp_read(a));
  endtask

  // Polls STATUS until the DUT reports idle and empty, bounded by max_rd reads.
  task automatic wait_drain(input string tag, input int max_rd);
    logic [31:0] d;
    for (int i = 0; i < max_rd; i++) begin
      bus_rd(A_STATUS, d);
      chk({tag, "_poll"}, d, exp_read(A_STATUS));
      if ((d & 32'h1F7) == 32'h4) break;
    end
    chk({tag, "_idle"}, d & 32'h1F7, 32'h4);
  endtask

  logic [31:0] rd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    bus_rd(A_STATUS, rd); chk("rst_status", rd, 32'h0000_0004);
    bus_rd(A_DIV, rd);    chk("rst_div", rd, 32'h0000_0364);
    chk("rst_tx", tx_o, 1'b1);

    bus_wr(A_DIV, 32'd4);
    bus_wr(A_DATA, 32'hA5);
    repeat (48) bus_rd_chk("a5_status", A_STATUS);
    wait_drain("a5", 100);

    bus_wr(A_DIV, 32'd2);
    for (int i = 0; i < 9; i++) bus_wr(A_DATA, $urandom);
    bus_rd(A_STATUS, rd);
    chk("b2b_status", rd, exp_read(A_STATUS));
    chk("b2b_peak", rd[8:4], 32'd8);
    wait_drain("b2b", 400);
    bus_rd(A_STATUS, rd); chk("b2b_no_ovf", rd[3], 1'b0);

    bus_wr(A_DIV, 32'd100);
    for (int i = 0; i < 10; i++) bus_wr(A_DATA, $urandom);
    bus_rd(A_STATUS, rd);
    chk("ovf_status", rd, exp_read(A_STATUS));
    chk("ovf_set", rd[3], 1'b1);
    bus_wr(A_STATUS, 32'h8);
    bus_rd(A_STATUS, rd);
    chk("ovf_clear", rd[3], 1'b0);
    bus_wr(A_DIV, 32'd3);

    bus_wr(BASE + 32'h20, 32'h55);
    bus_wr(BASE + 32'h28, 32'h7);
    bus_rd(BASE + 32'h20, rd); chk("miss_rd", rd, 32'h0);
    bus_wr(A_RSVD, 32'hFFFF_FFFF);
    bus_rd(A_RSVD, rd);        chk("rsvd_rd", rd, 32'h0);
    bus_rd(A_DIV, rd);         chk("div_kept", rd, 32'h3);
    bus_rd_chk("miss_status", A_STATUS);
    wait_drain("ovf", 1500);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus_wr(A_DATA, $urandom);
        4:          bus_wr(A_DIV, $urandom_range(0, 4));
        5:          bus_wr(A_STATUS, $urandom);
        6:          bus_wr(BASE + 32'h10 * $urandom_range(1, 1000), $urandom);
        7:          bus_nowr(BASE + 4 * $urandom_range(0, 2), $urandom);
        8:          bus_rd_chk("rnd_rd", BASE + 4 * $urandom_range(0, 3));
        default:    bus_rd_chk("rnd_miss", BASE - 32'h10 * $urandom_range(1, 8) + 4 * $urandom_range(0, 3));
      endcase
    end
    wait_drain("rnd", 600);

    bus_wr(A_DIV, 32'd5);
    bus_wr(A_DATA, 32'h3C);
    bus_wr(A_DATA, 32'hC3);
    repeat (20) bus_rd_chk("pre_rst", A_STATUS);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("rst_mid_tx", tx_o, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_rd(A_STATUS, rd); chk("post_rst_status", rd, 32'h4);
    repeat (100) bus_rd_chk("post_rst_poll", A_STATUS);
    chk("post_rst_tx", tx_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Memory-mapped UART transmitter on the CPU data-memory port (downstream of the CPU's mem_addr/mem_wr_data/mem_wr_sig/mem_rd_data).

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, base of the 16-byte register window; bits [3:0] SHALL be zero.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; SHALL be a power of two, 2..16.
REQ-003 Parameter DIV_RESET, default 16'd868, baud divisor after reset (100 MHz / 115200).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port mem_addr_i  input  32  CPU byte address.
REQ-007 Port mem_wr_data_i  input  32  CPU store data.
REQ-008 Port mem_wr_sig_i  input  1  CPU store strobe, one cycle per store.
REQ-009 Port mem_rd_data_o  output  32  register read data, combinational.
REQ-010 Port tx_o  output  1  serial line, idle high.

Function
REQ-011 Hit = mem_addr_i[31:4] == BASE_ADDR[31:4]; offset = mem_addr_i[3:2].
REQ-012 Registers: 0 DATA (write-only), 1 STATUS, 2 DIV, 3 reserved (reads 0, writes ignored).
REQ-013 mem_rd_data_o SHALL be 0 when not hit, so bus ORing is safe; same-cycle combinational read, no wait states.
REQ-014 STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] FIFO count, others 0.
REQ-015 DIV read: {16'b0, div}; DIV write loads mem_wr_data_i[15:0] on the edge; value 0 SHALL be treated as 1.
REQ-016 DATA write with FIFO not full pushes mem_wr_data_i[7:0]; with FIFO full, data is dropped and overflow is set.
REQ-017 STATUS write with bit3 = 1 clears overflow; a same-cycle set (DATA-full push) wins over the clear.
REQ-018 FSM states IDLE, START, DATA, STOP.
- IDLE: when FIFO not empty, pop the head into the shift register, latch div, go to START.
- START: tx_o = 0.
- DATA: tx_o = shift[0], 8 bits LSB first.
- STOP: tx_o = 1, then IDLE.
REQ-019 Each bit period SHALL last exactly latched-div cycles; a bit counter (0..7) advances DATA.
REQ-020 Latency: DATA write at edge N into an idle, empty block SHALL drive tx_o low from edge N+2.
REQ-021 DIV written mid-frame SHALL take effect only at the next frame start.
REQ-022 A push and pop in the same cycle SHALL both occur, with count unchanged; a push to a full FIFO with a same-cycle pop SHALL still be rejected.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-024 Back-to-back bytes: after STOP completes, IDLE pops next cycle, so the inter-frame gap is exactly one clock.
REQ-025 Writes without hit, or with mem_wr_sig_i low, SHALL have no effect.

Reset
REQ-026 Reset state, asynchronous:
- FSM = IDLE, tx_o = 1.
- FIFO empty (pointers 0, count 0), overflow = 0.
- div = DIV_RESET, shift/bit/baud counters = 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (tx_o high) and discard FIFO contents.

Structure
REQ-028 A shared package SHALL hold the register offsets (DATA/STATUS/DIV), STATUS bit indices, and the FSM state enumeration.
REQ-029 The FIFO SHALL be a separate sub-module uart_tx_fifo (push/pop/full/empty/count, async active-low reset); decode and FSM stay in uart_tx_periph.

Verification
REQ-030 Reset, then read STATUS -> 0x0000_0004; read DIV -> 0x0000_0364; tx_o = 1.
REQ-031 DIV = 4, write DATA 0xA5 -> tx_o levels 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles; start bit begins 2 edges after the write; busy returns to 0 after the stop bit.
REQ-032 DIV = 2, write 9 bytes back-to-back while idle -> all 9 transmitted in order (first popped immediately); no overflow; STATUS count peaks at 8.
REQ-033 DIV = 100, write 10 bytes -> bytes 1..9 accepted, 10th dropped, STATUS bit3 = 1; write STATUS 0x8 -> bit3 = 0.
REQ-034 Read/write at BASE_ADDR + 0x20 and at reserved offset 0xC -> mem_rd_data_o = 0; FIFO and DIV unchanged.
REQ-035 Assert reset_n low during a data bit -> tx_o = 1 the same cycle; after release, STATUS = 0x4 and no residual frame.
